// File: rtl/mchan_ext_pkg.sv
// Shared types for the external-side outstanding-transaction table.
// Field widths here set the default widths of ext_opc_tbl.
package mchan_ext_pkg;

    localparam int MCHAN_SID_W  = 2;
    localparam int MCHAN_ADD_W  = 12;
    localparam int MCHAN_OPC_W  = 12;
    localparam int MCHAN_TID_W  = 4;
    localparam int MCHAN_LEN_W  = 15;

    // One table entry: everything needed to route response beats back to TCDM.
    typedef struct packed {
        logic [MCHAN_OPC_W-1:0] opc;
        logic [MCHAN_LEN_W-1:0] len;
        logic [2:0]             ext_add;
        logic [MCHAN_ADD_W-1:0] tcdm_add;
        logic [MCHAN_SID_W-1:0] sid;
    } ext_opc_entry_t;

    localparam int EXT_OPC_ENTRY_W = $bits(ext_opc_entry_t);

    // The TCDM side sees the opposite direction of the external side: flip
    // the load/store bit. Anything other than a clean 0 is treated as 1.
    function automatic logic [MCHAN_OPC_W-1:0] inv_ld_st(input logic [MCHAN_OPC_W-1:0] opc);
        logic [MCHAN_OPC_W-1:0] res;
        res    = opc;
        res[0] = (opc[0] === 1'b0);
        return res;
    endfunction

endpackage

// File: rtl/ext_tid_alloc.sv
// Lowest-free priority encoder: gnt_o when any valid_i bit is clear,
// tid_o is the lowest index whose valid_i bit is clear.
module ext_tid_alloc #(
    parameter int NB_TID    = 16,
    parameter int TID_WIDTH = 4
) (
    input  logic [NB_TID-1:0]    valid_i,
    output logic                 gnt_o,
    output logic [TID_WIDTH-1:0] tid_o
);

    // Scan from the top down so the lowest free index wins.
    always_comb begin
        gnt_o = ~&valid_i;
        tid_o = '0;
        for (int i = NB_TID - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                tid_o = TID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/ext_opc_tbl.sv
// Outstanding-transaction table for the DMA external unit: allocates TIDs,
// stores per-TID TCDM context, returns it on response beats and retires the
// TID on the last beat. Optional per-entry age tracking is enabled with the
// macro EXT_OPC_TBL_TIMEOUT_EN (adds timeout_o / timeout_tid_o).
module ext_opc_tbl
    import mchan_ext_pkg::*;
#(
    parameter int TRANS_SID_WIDTH = MCHAN_SID_W,
    parameter int TCDM_ADD_WIDTH  = MCHAN_ADD_W,
    parameter int TCDM_OPC_WIDTH  = MCHAN_OPC_W,
    parameter int EXT_TID_WIDTH   = MCHAN_TID_W,
    parameter int MCHAN_LEN_WIDTH = MCHAN_LEN_W,
    parameter int NB_TID          = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alloc_req_i,
    output logic                       alloc_gnt_o,
    output logic [EXT_TID_WIDTH-1:0]   alloc_tid_o,
    input  logic [TCDM_OPC_WIDTH-1:0]  opc_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] len_i,
    input  logic [TCDM_ADD_WIDTH-1:0]  r_add_i,
    input  logic [2:0]                 add_i,
    input  logic [TRANS_SID_WIDTH-1:0] sid_i,
    input  logic                       r_valid_i,
    input  logic [EXT_TID_WIDTH-1:0]   r_tid_i,
    input  logic                       r_last_i,
    output logic                       r_hit_o,
    output logic [TCDM_OPC_WIDTH-1:0]  tcdm_opc_o,
    output logic [MCHAN_LEN_WIDTH-1:0] tcdm_len_o,
    output logic [MCHAN_LEN_WIDTH-1:0] trans_rx_len_o,
    output logic [TCDM_ADD_WIDTH-1:0]  tcdm_add_o,
    output logic [2:0]                 trans_rx_tcdm_add_o,
    output logic [2:0]                 trans_rx_ext_add_o,
    output logic [TRANS_SID_WIDTH-1:0] tcdm_sid_o,
    output logic [TRANS_SID_WIDTH-1:0] synch_sid_o,
    output logic                       r_err_o,
    output logic                       busy_o,
    output logic                       full_o,
    output logic [EXT_TID_WIDTH:0]     nb_outstanding_o
`ifdef EXT_OPC_TBL_TIMEOUT_EN
    ,
    output logic                       timeout_o,
    output logic [EXT_TID_WIDTH-1:0]   timeout_tid_o
`endif
);

    // The table is indexed over the full TID space; slots at or above NB_TID
    // are tied to zero so an out-of-range lookup naturally misses with zeros.
    localparam int TID_SPACE = 2 ** EXT_TID_WIDTH;
    localparam int CNT_W     = EXT_TID_WIDTH + 1;

    // Reject configurations the table cannot represent.
    if (NB_TID < 1 || NB_TID > TID_SPACE || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ext_opc_tbl: illegal NB_TID or TIMEOUT_CYCLES");
    end

    logic [TID_SPACE-1:0]   valid_q;
    logic [TID_SPACE-1:0]   valid_d;
    ext_opc_entry_t         mem_q [TID_SPACE];
    ext_opc_entry_t         wr_entry;
    ext_opc_entry_t         rd_entry;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   r_err_q;
    logic                   r_err_d;
    logic                   alloc_gnt;
    logic [EXT_TID_WIDTH-1:0] alloc_tid;
    logic                   alloc_fire;
    logic                   r_hit;
    logic                   retire;

    // Grant depends only on registered state, so a same-cycle retire never
    // turns into a grant while full.
    ext_tid_alloc #(
        .NB_TID    (NB_TID),
        .TID_WIDTH (EXT_TID_WIDTH)
    ) u_alloc (
        .valid_i (valid_q[NB_TID-1:0]),
        .gnt_o   (alloc_gnt),
        .tid_o   (alloc_tid)
    );

    assign alloc_fire = alloc_req_i & alloc_gnt;
    assign r_hit      = valid_q[r_tid_i];
    assign retire     = r_valid_i & r_last_i & r_hit;
    assign rd_entry   = mem_q[r_tid_i];

    assign wr_entry.opc      = opc_i;
    assign wr_entry.len      = len_i;
    assign wr_entry.ext_add  = add_i;
    assign wr_entry.tcdm_add = r_add_i;
    assign wr_entry.sid      = sid_i;

    // Next valid vector: set the granted slot, clear the retired one.
    // Alloc and retire can never name the same slot (granted slot is free,
    // retired slot is valid).
    always_comb begin
        valid_d = valid_q;
        if (alloc_fire) begin
            valid_d[alloc_tid] = 1'b1;
        end
        if (retire) begin
            valid_d[r_tid_i] = 1'b0;
        end
    end

    // Occupancy: +1 on grant, -1 on retire, unchanged when both happen.
    always_comb begin
        count_d = count_q;
        case ({alloc_fire, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        r_err_d = r_valid_i & ~r_hit;
    end

    for (genvar gi = 0; gi < TID_SPACE; gi++) begin : g_ent
        if (gi < NB_TID) begin : g_used
            logic           v_q;
            logic           v_d;
            ext_opc_entry_t m_q;
            ext_opc_entry_t m_d;

            // Entry payload is written only on its own grant; retire keeps it.
            always_comb begin
                v_d = valid_d[gi];
                m_d = m_q;
                if (alloc_fire && alloc_tid == EXT_TID_WIDTH'(gi)) begin
                    m_d = wr_entry;
                end
            end

            // Per-entry state, cleared by reset.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    v_q <= 1'b0;
                    m_q <= '0;
                end else begin
                    v_q <= v_d;
                    m_q <= m_d;
                end
            end

            assign valid_q[gi] = v_q;
            assign mem_q[gi]   = m_q;
        end else begin : g_unused
            assign valid_q[gi] = 1'b0;
            assign mem_q[gi]   = '0;
        end
    end

    // Occupancy counter and the one-cycle error pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            r_err_q <= 1'b0;
        end else begin
            count_q <= count_d;
            r_err_q <= r_err_d;
        end
    end

    assign alloc_gnt_o         = alloc_gnt;
    assign alloc_tid_o         = alloc_tid;
    assign r_hit_o             = r_hit;
    assign tcdm_opc_o          = inv_ld_st(rd_entry.opc);
    assign tcdm_len_o          = rd_entry.len;
    assign trans_rx_len_o      = rd_entry.len;
    assign tcdm_add_o          = rd_entry.tcdm_add;
    assign trans_rx_tcdm_add_o = rd_entry.tcdm_add[2:0];
    assign trans_rx_ext_add_o  = rd_entry.ext_add;
    assign tcdm_sid_o          = rd_entry.sid;
    assign synch_sid_o         = rd_entry.sid;
    assign r_err_o             = r_err_q;
    assign busy_o              = (count_q != '0);
    assign full_o              = (count_q == CNT_W'(NB_TID));
    assign nb_outstanding_o    = count_q;

`ifdef EXT_OPC_TBL_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NB_TID-1:0]        expired_d;
    logic                     to_any;
    logic [EXT_TID_WIDTH-1:0] to_tid;
    logic                     timeout_q;
    logic [EXT_TID_WIDTH-1:0] timeout_tid_q;

    for (genvar gi = 0; gi < NB_TID; gi++) begin : g_age
        logic [AGE_W-1:0] age_q;
        logic [AGE_W-1:0] age_d;

        // Age restarts on grant and saturates at the limit while valid.
        always_comb begin
            age_d = age_q;
            if (alloc_fire && alloc_tid == EXT_TID_WIDTH'(gi)) begin
                age_d = '0;
            end else if (valid_q[gi] && age_q != AGE_W'(TIMEOUT_CYCLES)) begin
                age_d = age_q + AGE_W'(1);
            end
        end

        // Age register.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                age_q <= '0;
            end else begin
                age_q <= age_d;
            end
        end

        // Uses next-state valid so a retire drops the indication right away.
        assign expired_d[gi] = valid_d[gi] && (age_d == AGE_W'(TIMEOUT_CYCLES));
    end

    // Same encoder, inverted sense: the lowest "free" slot is the lowest
    // expired one.
    ext_tid_alloc #(
        .NB_TID    (NB_TID),
        .TID_WIDTH (EXT_TID_WIDTH)
    ) u_timeout_sel (
        .valid_i (~expired_d),
        .gnt_o   (to_any),
        .tid_o   (to_tid)
    );

    // Registered timeout report.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timeout_q     <= 1'b0;
            timeout_tid_q <= '0;
        end else begin
            timeout_q     <= to_any;
            timeout_tid_q <= to_tid;
        end
    end

    assign timeout_o     = timeout_q;
    assign timeout_tid_o = timeout_tid_q;
`else
    // Age tracking not built; TIMEOUT_CYCLES only participates in the
    // configuration check above.
`endif

endmodule

// File: doc/ext_opc_tbl.md
Name: ext_opc_tbl

Overview:
Outstanding-transaction table for the external (AXI-side) unit of the DMA.
- Hands out free transaction IDs and stores per-TID TCDM-side context (opcode, length, TCDM address, ext address LSBs, stream ID).
- Returns that context when a response beat arrives, and retires the TID on the last beat.
- Adds what a plain indexed buffer lacks: TID allocation, valid tracking, occupancy/full status, and error flagging on responses to unallocated TIDs.

Parameters:
TRANS_SID_WIDTH, 2, stream/synch ID width
TCDM_ADD_WIDTH, 12, TCDM address width
TCDM_OPC_WIDTH, 12, TCDM opcode width; bit 0 = load/store
EXT_TID_WIDTH, 4, external TID width
MCHAN_LEN_WIDTH, 15, transfer length width
NB_TID, 16, number of usable TIDs; 1 <= NB_TID <= 2**EXT_TID_WIDTH
TIMEOUT_CYCLES, 1024, age limit; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
alloc_req_i  in  1  request a TID and store the entry fields
alloc_gnt_o  out  1  a free TID exists; handshake = req & gnt
alloc_tid_o  out  EXT_TID_WIDTH  granted TID (lowest free index)
opc_i  in  TCDM_OPC_WIDTH  opcode to store
len_i  in  MCHAN_LEN_WIDTH  length to store
r_add_i  in  TCDM_ADD_WIDTH  TCDM address to store
add_i  in  3  external address LSBs to store
sid_i  in  TRANS_SID_WIDTH  stream ID to store
r_valid_i  in  1  response beat present
r_tid_i  in  EXT_TID_WIDTH  response TID (lookup index)
r_last_i  in  1  last beat; retires the entry
r_hit_o  out  1  entry r_tid_i is valid
tcdm_opc_o  out  TCDM_OPC_WIDTH  stored opcode with bit 0 inverted
tcdm_len_o, trans_rx_len_o  out  MCHAN_LEN_WIDTH  stored length
tcdm_add_o  out  TCDM_ADD_WIDTH  stored TCDM address
trans_rx_tcdm_add_o  out  3  tcdm_add_o[2:0]
trans_rx_ext_add_o  out  3  stored external address LSBs
tcdm_sid_o, synch_sid_o  out  TRANS_SID_WIDTH  stored stream ID
r_err_o  out  1  registered pulse: response to an invalid TID
busy_o  out  1  at least one entry valid
full_o  out  1  all NB_TID entries valid
nb_outstanding_o  out  EXT_TID_WIDTH+1  count of valid entries

Behaviour:
- State: valid[NB_TID], mem[NB_TID], count, r_err.
- Reset (rst_ni=0 at posedge): valid=0, mem=0, count=0, r_err_o=0.
  - Reset values: alloc_gnt_o=1, alloc_tid_o=0, busy_o=0, full_o=0, r_hit_o=0.
  - Reset mid-operation drops all outstanding entries with no error reported.
- Allocation: alloc_gnt_o = |~valid, computed from the registered valid vector only. alloc_tid_o = lowest index with valid=0.
  - On handshake, at the next posedge: valid[tid]=1 and mem[tid]={opc_i,len_i,add_i,r_add_i,sid_i}.
  - No grant while full, even if a retire happens in the same cycle; the freed TID is usable the following cycle.
- Lookup: combinational from r_tid_i. Read outputs are always driven from mem[r_tid_i], regardless of r_valid_i.
  - tcdm_opc_o = stored opc with bit 0 inverted. Bit 0 = 1, X or Z maps to 0.
  - r_hit_o = valid[r_tid_i]. An r_tid_i >= NB_TID gives r_hit_o=0 and all read outputs 0.
- Retire: r_valid_i & r_last_i & r_hit_o clears valid[r_tid_i] at the next posedge. mem is kept, not cleared.
- Error: r_valid_i & ~r_hit_o sets r_err_o=1 for exactly the next cycle. valid, mem and count are unchanged.
- Count update per cycle: count += alloc handshake − retire.
  - Alloc and retire in the same cycle always target different TIDs, so count is unchanged.
  - busy_o = count != 0; full_o = count == NB_TID. Both are registered-state derived.
- Count never wraps: alloc is blocked when full, and retire requires a valid entry.

Optional Feature:
Macro EXT_OPC_TBL_TIMEOUT_EN.
- With the macro:
  - Each entry has an age counter, cleared on allocation and incremented each cycle while valid, saturating at TIMEOUT_CYCLES.
  - Extra outputs timeout_o (1) and timeout_tid_o (EXT_TID_WIDTH) are registered and report the lowest-index entry whose age reached TIMEOUT_CYCLES.
  - Retiring that entry clears the indication on the next cycle.
- Without the macro: no counters and no extra ports.

Decomposition:
- Package mchan_ext_pkg holds:
  - packed struct ext_opc_entry_t {opc, len, ext_add, tcdm_add, sid};
  - localparam EXT_OPC_ENTRY_W;
  - function inv_ld_st(opc).
- Sub-module ext_tid_alloc: parametric lowest-free priority encoder over valid[NB_TID], outputs gnt and tid. It is reused for the timeout-lowest-index search.

Test Plan:
- Reset, then 3 back-to-back allocs -> alloc_tid_o 0,1,2; nb_outstanding_o=3; busy_o=1.
- Retire TID 1 (r_valid_i=1, r_last_i=1), then alloc -> granted TID 1; count back to 3.
- Fill all 16 -> full_o=1, alloc_gnt_o=0. Alloc+retire of TID 5 in the same cycle -> no grant that cycle; next cycle gnt=1, tid=5.
- Store opc=12'h0A2, r_add=12'h3F5, add=3'b110, sid=2, then lookup -> tcdm_opc_o=12'h0A3, trans_rx_tcdm_add_o=3'b101, trans_rx_ext_add_o=3'b110, synch_sid_o=2, r_hit_o=1.
- r_valid_i on unallocated TID 9 -> r_err_o=1 for one cycle; count and valid unchanged. Non-last beat on a valid TID -> no retire.
- With EXT_OPC_TBL_TIMEOUT_EN and TIMEOUT_CYCLES=8: alloc TID 0, no response -> timeout_o=1, timeout_tid_o=0 by cycle 9; retire -> timeout_o=0 the next cycle.
